mmio_uart_bridge: RTL
=====================

# mmio_uart_bridge

Host-side initiator for the FPro MMIO bus. It takes a byte stream from a UART receiver, decodes framed read/write commands, and issues single-cycle transactions on the `mmio_cs`/`mmio_wr`/`mmio_rd` bus that the MMIO subsystem responds to. Read data and acknowledges go back as bytes toward a UART transmitter. This lets a PC drive any slot register without a processor, for bring-up and test.

## Interface

- `TIMEOUT_CYCLES`, default 1_000_000: maximum idle cycles allowed between bytes inside a frame.
- `clk`  in  1  system clock; everything is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe that qualifies `rx_data`.
- `tx_data`  out  8  response byte.
- `tx_valid`  out  1  response byte available.
- `tx_ready`  in  1  transmitter accepts the byte when `tx_valid && tx_ready`.
- `mmio_cs`  out  1  bus chip select.
- `mmio_wr`  out  1  write strobe.
- `mmio_rd`  out  1  read strobe.
- `mmio_addr`  out  21  word address.
- `mmio_wr_data`  out  32  write data.
- `mmio_rd_data`  in  32  read data, valid in the same cycle as `mmio_rd`.
- `busy`  out  1  high in every state except IDLE.
- `timeout`  out  1  one-cycle pulse when a frame is aborted by timeout.

## Operation

**Frame format**
- Write: `0x57`, then A2 A1 A0, then D3 D2 D1 D0.
- Read: `0x52`, then A2 A1 A0.
- Multi-byte fields are big-endian.
- `mmio_addr` = {A2[4:0], A1, A0}. A2[7:5] are ignored.

**States:** IDLE, ADDR, DATA, BUS, RESP.
- **IDLE**
  - `rx_valid` with `0x57` or `0x52`: latch the opcode, clear the byte counter, go to ADDR.
  - Any other byte: load the response `0x3F` (length 1), go to RESP.
- **ADDR**
  - Each `rx_valid` shifts the byte into the address register.
  - On the 3rd byte: a write goes to DATA, a read goes to BUS.
- **DATA**
  - Each `rx_valid` shifts the byte into the write-data register.
  - On the 4th byte, go to BUS.
- **BUS** lasts exactly one cycle.
  - Drives `mmio_cs=1`, and either `mmio_wr=1` or `mmio_rd=1`.
  - On a read, `mmio_rd_data` is captured at the end of this cycle into the response register (length 4, MSB first).
  - On a write, the response is `0x4B` (length 1).
  - Go to RESP.
- **RESP**
  - `tx_valid=1` and `tx_data` = current response byte.
  - On each handshake, advance to the next byte.
  - After the last handshake, go to IDLE.
  - There is no timeout in RESP; `tx_ready` may stall it indefinitely.

**Rules**
- `rx_valid` in BUS or RESP is dropped silently, including the cycle of the last handshake.
- `mmio_cs`, `mmio_wr` and `mmio_rd` are registered and low in every state except BUS.
- `mmio_addr` and `mmio_wr_data` hold their last values between transactions.

**Timeout**
- A counter runs in ADDR and DATA. It clears on entering those states and on every accepted byte.
- When it reaches `TIMEOUT_CYCLES - 1` with no `rx_valid` that cycle:
  - go to IDLE,
  - pulse `timeout` for one cycle,
  - send no response.
- If `rx_valid` coincides with the limit cycle, the byte wins: it is accepted and the counter clears.
- Counter width is `$clog2(TIMEOUT_CYCLES)`.

**Reset**
- Asserting `reset` at any point, including mid-frame or mid-response, returns the block to IDLE immediately.
- All outputs go to 0. Partial frames and queued response bytes are discarded.

## Timing

- Reset values: `tx_data=0`, `tx_valid=0`, `mmio_cs=0`, `mmio_wr=0`, `mmio_rd=0`, `mmio_addr=0`, `mmio_wr_data=0`, `busy=0`, `timeout=0`.
- Last frame byte arrives with `rx_valid` in cycle N:
  - bus strobe in cycle N+1,
  - first `tx_valid` in cycle N+2.
- `tx_data` is stable while `tx_valid && !tx_ready`.
- `tx_valid` never drops without a handshake.
- Back-to-back handshakes (`tx_ready` held high) deliver one byte per cycle. A 4-byte read response occupies cycles N+2 to N+5, and the block is in IDLE at N+6.
- An unknown opcode at cycle N gives `tx_valid` with `0x3F` at N+1.
- `busy` rises the cycle after the first opcode byte and falls the cycle after the last handshake or timeout.

## Test plan

- **Write:** bytes 57 00 00 82 DE AD BE EF → exactly one cycle with `cs=1`, `wr=1`, `addr=0x000082`, `wr_data=0xDEADBEEF`, then a single `tx` byte `0x4B`.
- **Read:** bytes 52 1F 00 C1, with `mmio_rd_data=0x12345678` in the BUS cycle → one `cs&rd` cycle at `addr=0x1F00C1`, then `tx` bytes 12 34 56 78 in order.
- **Backpressure:** read frame with `tx_ready` low for 10 cycles between bytes, and extra `rx` bytes `0xAA` injected during RESP → `tx_data` held constant while stalled, response unchanged, `0xAA` bytes ignored, and the next frame decodes normally.
- **Timeout:** `TIMEOUT_CYCLES=16`; send 57 00, then silence → `timeout` pulses 16 cycles after the last byte, no bus cycle, no `tx`; a following valid read completes.
- **Boundary:** unknown opcode `0x00` → single `0x3F` response. Also drive `rx_valid` exactly on the timeout limit cycle → byte accepted, no `timeout` pulse.
- **Reset mid-operation:** assert `reset` during DATA and again during RESP → all outputs 0 immediately, no bus strobe, no further `tx` bytes.

Source files
------------

// File: rtl/mmio_uart_bridge.sv
// mmio_uart_bridge
// Turns a framed byte stream from a UART receiver into single-cycle FPro MMIO
// bus transactions, and returns read data or an acknowledge byte toward a UART
// transmitter. Frames:
//   write : 0x57 A2 A1 A0 D3 D2 D1 D0   -> bus write, reply 0x4B
//   read  : 0x52 A2 A1 A0               -> bus read,  reply D3 D2 D1 D0
//   other : any other opcode byte        -> reply 0x3F
// A frame that stalls for TIMEOUT_CYCLES between bytes is dropped silently
// apart from a one-cycle timeout pulse.
module mmio_uart_bridge #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        mmio_cs,
    output logic        mmio_wr,
    output logic        mmio_rd,
    output logic [20:0] mmio_addr,
    output logic [31:0] mmio_wr_data,
    input  logic [31:0] mmio_rd_data,
    output logic        busy,
    output logic        timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] OP_WRITE     = 8'h57;
    localparam logic [7:0] OP_READ      = 8'h52;
    localparam logic [7:0] RESP_ACK     = 8'h4B;
    localparam logic [7:0] RESP_UNKNOWN = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic              is_write_q;
    logic [1:0]        byte_cnt_q;
    logic [CNT_W-1:0]  idle_cnt_q;
    logic [20:0]       addr_sh_q;
    logic [23:0]       data_sh_q;
    logic [31:0]       resp_q;
    logic [1:0]        resp_left_q;

    logic              byte_take;
    logic              opcode_known;
    logic [20:0]       addr_next;
    logic [31:0]       data_next;

    // Word address from the 24-bit big-endian address field: the top three
    // bits of A2 fall outside the 21-bit MMIO space and are dropped.
    function automatic logic [20:0] word_addr(input logic [12:0] upper, input logic [7:0] low);
        return {upper, low};
    endfunction

    assign opcode_known = (rx_data == OP_WRITE) || (rx_data == OP_READ);

    // Address/data as they will look once the byte on rx_data is shifted in;
    // used so the last frame byte reaches the bus registers without a bubble.
    assign addr_next = word_addr(addr_sh_q[12:0], rx_data);
    assign data_next = {data_sh_q, rx_data};

    assign tx_valid = (state_q == S_RESP);
    assign tx_data  = resp_q[31:24];
    assign busy     = (state_q != S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode, byte acceptance and timeout detection.
    always_comb begin
        state_d   = state_q;
        byte_take = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    state_d = opcode_known ? S_ADDR : S_RESP;
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    byte_take = 1'b1;
                    if (byte_cnt_q == 2'd2) begin
                        state_d = is_write_q ? S_DATA : S_BUS;
                    end
                end else if (idle_cnt_q == CNT_LIMIT) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    byte_take = 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_BUS;
                    end
                end else if (idle_cnt_q == CNT_LIMIT) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_BUS: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (tx_ready && (resp_left_q == 2'd0)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Frame bookkeeping: opcode kind, byte position and inter-byte idle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_write_q <= 1'b0;
            byte_cnt_q <= 2'd0;
            idle_cnt_q <= '0;
        end else begin
            if ((state_q == S_IDLE) && rx_valid) begin
                is_write_q <= (rx_data == OP_WRITE);
            end

            // Every state change restarts the byte position, which covers
            // both entering ADDR and the ADDR -> DATA hand-over.
            if (state_q != state_d) begin
                byte_cnt_q <= 2'd0;
            end else if (byte_take) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
            end

            // The counter only advances while waiting for frame bytes; an
            // accepted byte restarts the window, even on the limit cycle.
            if (((state_q != S_ADDR) && (state_q != S_DATA)) || byte_take) begin
                idle_cnt_q <= '0;
            end else begin
                idle_cnt_q <= idle_cnt_q + CNT_W'(1);
            end
        end
    end

    // Frame field shift registers; fully rewritten by every frame.
    always_ff @(posedge clk) begin
        if (byte_take && (state_q == S_ADDR)) begin
            addr_sh_q <= addr_next;
        end
        if (byte_take && (state_q == S_DATA)) begin
            data_sh_q <= {data_sh_q[15:0], rx_data};
        end
    end

    // Bus strobes for the single BUS cycle; address and write data hold
    // between transactions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mmio_cs      <= 1'b0;
            mmio_wr      <= 1'b0;
            mmio_rd      <= 1'b0;
            mmio_addr    <= '0;
            mmio_wr_data <= '0;
        end else begin
            mmio_cs <= (state_d == S_BUS);
            mmio_wr <= (state_d == S_BUS) && is_write_q;
            mmio_rd <= (state_d == S_BUS) && !is_write_q;
            if (state_d == S_BUS) begin
                if (state_q == S_ADDR) begin
                    mmio_addr <= addr_next;
                end else begin
                    mmio_addr    <= addr_sh_q;
                    mmio_wr_data <= data_next;
                end
            end
        end
    end

    // Response byte queue: loaded for an unknown opcode or at the end of the
    // bus cycle, shifted out MSB first one byte per handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_q      <= '0;
            resp_left_q <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_valid && !opcode_known) begin
                        resp_q      <= {RESP_UNKNOWN, 24'h0};
                        resp_left_q <= 2'd0;
                    end
                end
                S_BUS: begin
                    if (is_write_q) begin
                        resp_q      <= {RESP_ACK, 24'h0};
                        resp_left_q <= 2'd0;
                    end else begin
                        resp_q      <= mmio_rd_data;
                        resp_left_q <= 2'd3;
                    end
                end
                S_RESP: begin
                    if (tx_ready) begin
                        resp_q <= {resp_q[23:0], 8'h00};
                        if (resp_left_q != 2'd0) begin
                            resp_left_q <= resp_left_q - 2'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
